// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl
// ----------------------------------------------------------------------------
// Hazard and stall controller for a five-stage in-order pipeline. It decides,
// every cycle, which pipeline registers advance and which of them capture a
// NOP. It handles three situations:
//   * load-use hazards: hold PC and IF/ID for one cycle and drop a bubble into ID/EX
//   * taken branches/jumps: flush IF/ID and bubble ID/EX
//   * data-memory waits: freeze everything up to EX/MEM and let MEM/WB drain
//     with bubbles until the memory acknowledges or a timeout is hit
// It also keeps three saturating performance counters.
//
// Parameters
//   TIMEOUT        cycles spent in MEM_WAIT without memAck before ERROR
//   CNT_WIDTH      width of each performance counter
//   RF_ADDR_WIDTH  register-file address width
//
// Ports
//   clk            pipeline clock
//   rst_n          asynchronous active-low reset
//   ifidRs1/Rs2    IF/ID source register addresses
//   idexRd         ID/EX destination register address
//   idexMemRead    ID/EX holds a load
//   exBranchTaken  EX resolved a taken branch or jump
//   memReq         MEM stage holds a load or store
//   memAck         data memory completes the access this cycle
//   pcEn..memwbEn  pipeline register enables (combinational)
//   ifidFlush      IF/ID loads a NOP when enabled
//   idexBubble     ID/EX loads a NOP when enabled
//   memwbBubble    MEM/WB loads a NOP when enabled
//   memErr         data-memory timeout flag, held until reset
//   ctrlState      current FSM state (0 INIT, 1 RUN, 2 MEM_WAIT, 3 ERROR)
//   luStallCnt     cycles stalled on a load-use hazard
//   memWaitCnt     cycles stalled on data memory
//   flushCnt       cycles in which a taken branch flushed the front end
// ============================================================================
module pipe_ctrl #(
  parameter int TIMEOUT       = 255,
  parameter int CNT_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RF_ADDR_WIDTH-1:0] ifidRs1,
  input  logic [RF_ADDR_WIDTH-1:0] ifidRs2,
  input  logic [RF_ADDR_WIDTH-1:0] idexRd,
  input  logic                     idexMemRead,
  input  logic                     exBranchTaken,
  input  logic                     memReq,
  input  logic                     memAck,
  output logic                     pcEn,
  output logic                     ifidEn,
  output logic                     idexEn,
  output logic                     exmemEn,
  output logic                     memwbEn,
  output logic                     ifidFlush,
  output logic                     idexBubble,
  output logic                     memwbBubble,
  output logic                     memErr,
  output logic [1:0]               ctrlState,
  output logic [CNT_WIDTH-1:0]     luStallCnt,
  output logic [CNT_WIDTH-1:0]     memWaitCnt,
  output logic [CNT_WIDTH-1:0]     flushCnt
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // The wait counter must be able to hold TIMEOUT itself.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Reaching this value before a further miss means the next miss is the
  // TIMEOUT-th one spent in MEM_WAIT.
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_WIDTH-1:0] r_lu_cnt;
  logic [CNT_WIDTH-1:0] r_mw_cnt;
  logic [CNT_WIDTH-1:0] r_fl_cnt;

  logic w_lu;          // load-use hazard between ID/EX and IF/ID
  logic w_mem_stall;   // memory is holding the pipeline this cycle
  logic w_run_eval;    // normal hazard rules are in force this cycle
  logic w_flush;       // taken branch flushes the front end
  logic w_lu_stall;    // load-use stall is applied
  logic w_run_free;    // nothing blocks the pipeline

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] res;
    if (&v) begin
      res = v;
    end else begin
      res = v + CNT_WIDTH'(1);
    end
    return res;
  endfunction

  // A load whose destination is x0 never creates a hazard.
  assign w_lu = idexMemRead
             && (idexRd != {RF_ADDR_WIDTH{1'b0}})
             && ((idexRd == ifidRs1) || (idexRd == ifidRs2));

  // Classify the cycle: memory stall, normal rule evaluation, or neither (INIT/ERROR).
  always_comb begin
    w_mem_stall = 1'b0;
    w_run_eval  = 1'b0;
    case (r_state)
      ST_RUN: begin
        // An access acknowledged in its own cycle needs no wait.
        if (memReq && !memAck) begin
          w_mem_stall = 1'b1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!memAck) begin
          w_mem_stall = 1'b1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      default: begin
        w_mem_stall = 1'b0;
        w_run_eval  = 1'b0;
      end
    endcase
  end

  // Branch beats load-use: the flushed instruction's hazard no longer matters.
  assign w_flush    = w_run_eval &&  exBranchTaken;
  assign w_lu_stall = w_run_eval && !exBranchTaken &&  w_lu;
  assign w_run_free = w_run_eval && !exBranchTaken && !w_lu;

  // Enables and NOP controls follow directly from the cycle classification.
  always_comb begin
    pcEn        = w_flush | w_run_free;
    ifidEn      = w_flush | w_run_free;
    idexEn      = w_run_eval;
    exmemEn     = w_run_eval;
    // MEM/WB keeps moving during a memory stall so WB drains with bubbles.
    memwbEn     = w_run_eval | w_mem_stall;
    ifidFlush   = w_flush;
    idexBubble  = w_flush | w_lu_stall;
    memwbBubble = w_mem_stall;
    // ERROR is only left through reset, which makes this flag sticky.
    memErr      = (r_state == ST_ERROR);
  end

  assign ctrlState  = r_state;
  assign luStallCnt = r_lu_cnt;
  assign memWaitCnt = r_mw_cnt;
  assign flushCnt   = r_fl_cnt;

  // Controller FSM and data-memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_wait_cnt <= {WAIT_W{1'b0}};
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= {WAIT_W{1'b0}};
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (memAck) begin
            r_state <= ST_RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt >= WAIT_LIMIT) begin
              r_state <= ST_ERROR;
            end else begin
              r_state <= ST_MEM_WAIT;
            end
          end
        end
        ST_ERROR: begin
          r_state <= ST_ERROR;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Saturating performance counters, one per stall/flush cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt <= {CNT_WIDTH{1'b0}};
      r_mw_cnt <= {CNT_WIDTH{1'b0}};
      r_fl_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_lu_stall) begin
        r_lu_cnt <= sat_inc(r_lu_cnt);
      end else begin
        r_lu_cnt <= r_lu_cnt;
      end
      if (w_mem_stall) begin
        r_mw_cnt <= sat_inc(r_mw_cnt);
      end else begin
        r_mw_cnt <= r_mw_cnt;
      end
      if (w_flush) begin
        r_fl_cnt <= sat_inc(r_fl_cnt);
      end else begin
        r_fl_cnt <= r_fl_cnt;
      end
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL take parameter TIMEOUT, default 255, as the maximum number of data-memory wait cycles before the error state is entered.
REQ-002 The block SHALL take parameter CNT_WIDTH, default 32, as the width of each performance counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low: clk input 1 = pipeline clock; rst_n input 1 = reset, active-low, asynchronous.
REQ-004 The block SHALL have these ports, one per entry, after clk and rst_n:
- ifidRs1, ifidRs2 | input | RF_ADDR_WIDTH | IF/ID source register addresses
- idexRd | input | RF_ADDR_WIDTH | ID/EX destination register address
- idexMemRead | input | 1 | ID/EX holds a load
- exBranchTaken | input | 1 | EX resolved a taken branch or jump
- memReq | input | 1 | MEM stage holds a load or store
- memAck | input | 1 | data memory completes the access this cycle
- pcEn, ifidEn, idexEn, exmemEn, memwbEn | output | 1 | register enables
- ifidFlush, idexBubble, memwbBubble | output | 1 | load a NOP into that register when its enable is 1
- memErr | output | 1 | sticky data-memory timeout flag
- ctrlState | output | 2 | encoded FSM state
- luStallCnt, memWaitCnt, flushCnt | output | CNT_WIDTH | performance counters

Function
REQ-005 The FSM SHALL have states INIT=0, RUN=1, MEM_WAIT=2, ERROR=3, and ctrlState SHALL equal the current state.
REQ-006 The load-use hazard is defined as lu = idexMemRead && idexRd!=0 && (idexRd==ifidRs1 || idexRd==ifidRs2), and it SHALL be evaluated combinationally.
REQ-007 In INIT, all enables and bubble/flush outputs SHALL be 0, and the FSM SHALL move to RUN on the next clock unconditionally.
REQ-008 In RUN with memReq && !memAck, the block SHALL drive pcEn, ifidEn, idexEn, exmemEn = 0, memwbEn=1, memwbBubble=1, and go to MEM_WAIT; lu and exBranchTaken are ignored that cycle.
REQ-009 In RUN with exBranchTaken (and no memory wait), the block SHALL drive all enables=1, ifidFlush=1, idexBubble=1; the branch has priority over lu.
REQ-010 In RUN with lu (and no memory wait, no branch), the block SHALL drive pcEn=0, ifidEn=0, idexEn=1, idexBubble=1, and exmemEn=memwbEn=1.
REQ-011 Otherwise in RUN, all enables SHALL be 1 and all bubble/flush outputs SHALL be 0.
REQ-012 In MEM_WAIT with !memAck, the outputs SHALL be as in REQ-008 and the wait counter SHALL increment.
REQ-013 When the wait counter reaches TIMEOUT without memAck, the FSM SHALL enter ERROR.
REQ-014 In MEM_WAIT with memAck, the outputs SHALL be evaluated exactly as RUN per REQ-009..011 (the memory condition is satisfied), and the FSM SHALL return to RUN.
REQ-015 The wait counter SHALL clear on every entry to MEM_WAIT.
REQ-016 memAck in the same RUN cycle as memReq SHALL cause no wait (single-cycle access).
REQ-017 In ERROR, all enables SHALL be 0 and memErr SHALL be 1; only reset exits ERROR.
REQ-018 luStallCnt SHALL increment on each cycle in which REQ-010 applies.
REQ-019 memWaitCnt SHALL increment on each cycle in which REQ-008 or REQ-012 applies.
REQ-020 flushCnt SHALL increment on each cycle in which REQ-009 applies.
REQ-021 All counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-022 All outputs other than the counters and ctrlState SHALL be combinational from the state and inputs, with no added latency.

Reset
REQ-023 When rst_n=0, the block SHALL immediately set state=INIT, memErr=0, the wait counter=0, and all performance counters=0, independent of clk.
REQ-024 Reset asserted during MEM_WAIT or ERROR SHALL abandon the access, and the block SHALL restart at INIT after release.
REQ-025 The first clock edge after release SHALL move INIT to RUN.

Verification
REQ-026 Reset release, idle inputs -> 1 cycle with ctrlState=0 and all enables 0, then ctrlState=1 with all enables 1 and counters 0.
REQ-027 idexMemRead=1, idexRd=5, ifidRs2=5, for one cycle -> pcEn=0, ifidEn=0, idexBubble=1, luStallCnt=1; the same case with idexRd=0 -> no stall.
REQ-028 memReq=1 with memAck low for 3 cycles, then high -> 3 cycles with all upstream enables 0 and memwbBubble=1, memWaitCnt=3, then RUN with all enables 1.
REQ-029 exBranchTaken=1 together with lu=1 -> ifidFlush=1, idexBubble=1, pcEn=1, flushCnt+1, luStallCnt unchanged.
REQ-030 TIMEOUT=4, memReq=1 with memAck never asserted -> ERROR entered after 4 wait cycles, memErr=1, all enables 0; rst_n pulse -> INIT, memErr=0.
REQ-031 CNT_WIDTH=2 with 5 consecutive load-use cycles -> luStallCnt holds at 3.
